// File: rtl/kb_event_ctrl_pkg.sv
// Shared constants and decoder state encodings for the PS/2 keyboard event path.
package kb_event_ctrl_pkg;

  localparam logic [7:0] BRK    = 8'hF0;
  localparam logic [7:0] EXT    = 8'hE0;
  localparam logic [7:0] LSHIFT = 8'h12;
  localparam logic [7:0] RSHIFT = 8'h59;

  localparam int EV_W = 10;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } kb_state_e;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == EXT) || (b == BRK);
  endfunction

  function automatic logic is_shift(input logic [7:0] b);
    return (b == LSHIFT) || (b == RSHIFT);
  endfunction

endpackage

// File: rtl/kb_event_fifo.sv
// First-word-fall-through event FIFO with registered full/empty flags and a
// sticky overflow indicator for pushes dropped while full.
module kb_event_fifo #(
  parameter int W_SIZE = 2,
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic              rd_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              overflow_o
);

  localparam int DEPTH = 1 << W_SIZE;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [W_SIZE-1:0] wr_ptr_q, rd_ptr_q;
  logic [W_SIZE-1:0] wr_ptr_d, rd_ptr_d;
  logic              empty_q, full_q, overflow_q;
  logic              do_rd, do_wr;

  // A pop frees the slot a concurrent push needs, so push-while-full is legal then.
  assign do_rd    = rd_i & ~empty_q;
  assign do_wr    = wr_i & (~full_q | do_rd);
  assign wr_ptr_d = wr_ptr_q + W_SIZE'(1);
  assign rd_ptr_d = rd_ptr_q + W_SIZE'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_d;
      if (do_rd) rd_ptr_q <= rd_ptr_d;
      if (wr_i && !do_wr) overflow_q <= 1'b1;
      if (do_wr && !do_rd) begin
        empty_q <= 1'b0;
        full_q  <= (wr_ptr_d == rd_ptr_q);
      end else if (do_rd && !do_wr) begin
        full_q  <= 1'b0;
        empty_q <= (rd_ptr_d == wr_ptr_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= din_i;
  end

  // Head is forced to zero while empty so stale storage never reaches the outputs.
  assign dout_o     = empty_q ? '0 : mem_q[rd_ptr_q];
  assign empty_o    = empty_q;
  assign full_o     = full_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/kb_event_ctrl.sv
// PS/2 scan-byte decoder: folds E0/F0 prefixes into {ext,brk,code} events,
// tracks shift state, aborts stalled sequences and queues events in a FIFO.
module kb_event_ctrl
  import kb_event_ctrl_pkg::*;
#(
  parameter int W_SIZE   = 2,
  parameter int TOUT_CYC = 2_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_done_tick,
  input  logic [7:0] scan_out,
  input  logic       rd_en,
  output logic       ev_valid,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_brk,
  output logic       shift_on,
  output logic       fifo_full,
  output logic       overflow,
  output logic       err_tick
);

  localparam int              TW        = $clog2(TOUT_CYC + 1);
  localparam logic [TW-1:0]   TOUT_LAST = TW'(TOUT_CYC - 1);

  kb_state_e      state_q;
  logic [TW-1:0]  cnt_q;
  logic           shift_q;
  logic           err_q;

  logic           emit_d;
  logic           ext_d, brk_d;
  logic [EV_W-1:0] ev_head;
  logic           fifo_empty;

  // Event emission is combinational on the tick so the FIFO captures it at that edge.
  always_comb begin
    emit_d = 1'b0;
    ext_d  = 1'b0;
    brk_d  = 1'b0;
    if (scan_done_tick && !is_prefix(scan_out)) begin
      emit_d = 1'b1;
      ext_d  = (state_q == S_EXT) || (state_q == S_EXT_BRK);
      brk_d  = (state_q == S_BRK) || (state_q == S_EXT_BRK);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (scan_done_tick) begin
        cnt_q <= '0;
        case (state_q)
          S_IDLE: begin
            if (scan_out == EXT)      state_q <= S_EXT;
            else if (scan_out == BRK) state_q <= S_BRK;
          end
          S_EXT: begin
            if (scan_out == BRK)      state_q <= S_EXT_BRK;
            else if (scan_out != EXT) state_q <= S_IDLE;
          end
          default: begin
            if (is_prefix(scan_out)) err_q <= 1'b1;
            state_q <= S_IDLE;
          end
        endcase
      end else if (state_q == S_IDLE) begin
        cnt_q <= '0;
      end else if (cnt_q == TOUT_LAST) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
        err_q   <= 1'b1;
      end else begin
        cnt_q <= cnt_q + TW'(1);
      end
      // Shift tracking ignores FIFO space; extended codes never touch it.
      if (emit_d && !ext_d && is_shift(scan_out)) shift_q <= ~brk_d;
    end
  end

  kb_event_fifo #(
    .W_SIZE (W_SIZE),
    .DATA_W (EV_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .wr_i       (emit_d),
    .din_i      ({ext_d, brk_d, scan_out}),
    .rd_i       (rd_en),
    .dout_o     (ev_head),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full),
    .overflow_o (overflow)
  );

  assign ev_valid = ~fifo_empty;
  assign ev_ext   = ev_head[9];
  assign ev_brk   = ev_head[8];
  assign ev_code  = ev_head[7:0];
  assign shift_on = shift_q;
  assign err_tick = err_q;

endmodule

// File: tb/tb_kb_event_ctrl.sv
// Directed bench for kb_event_ctrl: per-cycle vector table plus a timeout sequence.
module tb_kb_event_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       scan_done_tick = 1'b0;
  logic [7:0] scan_out = 8'h00;
  logic       rd_en = 1'b0;
  logic       ev_valid, ev_ext, ev_brk, shift_on, fifo_full, overflow, err_tick;
  logic [7:0] ev_code;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  kb_event_ctrl #(.W_SIZE(2), .TOUT_CYC(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .scan_done_tick (scan_done_tick),
    .scan_out       (scan_out),
    .rd_en          (rd_en),
    .ev_valid       (ev_valid),
    .ev_code        (ev_code),
    .ev_ext         (ev_ext),
    .ev_brk         (ev_brk),
    .shift_on       (shift_on),
    .fifo_full      (fifo_full),
    .overflow       (overflow),
    .err_tick       (err_tick)
  );

  typedef struct {
    logic        rst_n;
    logic        tick;
    logic        rd;
    logic [7:0]  scan;
    logic [14:0] exp;   // {valid, ext, brk, code, shift, full, ovf, err}
  } vec_t;

  vec_t vecs[$];

  function automatic logic [14:0] outs();
    return {ev_valid, ev_ext, ev_brk, ev_code, shift_on, fifo_full, overflow, err_tick};
  endfunction

  task automatic add(input logic rst_n, input logic tick, input logic rd, input logic [7:0] scan,
                     input logic v, input logic x, input logic b, input logic [7:0] code,
                     input logic sh, input logic fu, input logic ov, input logic er);
    vec_t t;
    t.rst_n = rst_n; t.tick = tick; t.rd = rd; t.scan = scan;
    t.exp = {v, x, b, code, sh, fu, ov, er};
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [14:0] act, input logic [14:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got {v,x,b,code,sh,full,ovf,err}=%b_%b_%b_%h_%b_%b_%b_%b want %b_%b_%b_%h_%b_%b_%b_%b",
               name, act[14], act[13], act[12], act[11:4], act[3], act[2], act[1], act[0],
               req[14], req[13], req[12], req[11:4], req[3], req[2], req[1], req[0]);
    end
  endtask

  task automatic drive(input logic rst_n, input logic tick, input logic rd, input logic [7:0] scan);
    @(negedge clk);
    reset = rst_n; scan_done_tick = tick; rd_en = rd; scan_out = scan;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //  rst tick rd scan     v  x  b  code   sh fu ov er
    add(0, 0, 0, 8'h00,    0, 0, 0, 8'h00, 0, 0, 0, 0);
    add(1, 0, 0, 8'h00,    0, 0, 0, 8'h00, 0, 0, 0, 0);
    // make / break of 1C
    add(1, 1, 0, 8'h1C,    1, 0, 0, 8'h1C, 0, 0, 0, 0);
    add(1, 1, 0, 8'hF0,    1, 0, 0, 8'h1C, 0, 0, 0, 0);
    add(1, 1, 0, 8'h1C,    1, 0, 0, 8'h1C, 0, 0, 0, 0);
    add(1, 0, 1, 8'h00,    1, 0, 1, 8'h1C, 0, 0, 0, 0);
    add(1, 0, 1, 8'h00,    0, 0, 0, 8'h00, 0, 0, 0, 0);
    // extended make / break of 75
    add(1, 1, 0, 8'hE0,    0, 0, 0, 8'h00, 0, 0, 0, 0);
    add(1, 1, 0, 8'h75,    1, 1, 0, 8'h75, 0, 0, 0, 0);
    add(1, 1, 0, 8'hE0,    1, 1, 0, 8'h75, 0, 0, 0, 0);
    add(1, 1, 0, 8'hF0,    1, 1, 0, 8'h75, 0, 0, 0, 0);
    add(1, 1, 0, 8'h75,    1, 1, 0, 8'h75, 0, 0, 0, 0);
    add(1, 0, 1, 8'h00,    1, 1, 1, 8'h75, 0, 0, 0, 0);
    add(1, 0, 1, 8'h00,    0, 0, 0, 8'h00, 0, 0, 0, 0);
    // left shift held across another key
    add(1, 1, 0, 8'h12,    1, 0, 0, 8'h12, 1, 0, 0, 0);
    add(1, 1, 0, 8'h1C,    1, 0, 0, 8'h12, 1, 0, 0, 0);
    add(1, 1, 0, 8'hF0,    1, 0, 0, 8'h12, 1, 0, 0, 0);
    add(1, 1, 0, 8'h12,    1, 0, 0, 8'h12, 0, 0, 0, 0);
    add(1, 0, 1, 8'h00,    1, 0, 0, 8'h1C, 0, 0, 0, 0);
    add(1, 0, 1, 8'h00,    1, 0, 1, 8'h12, 0, 0, 0, 0);
    add(1, 0, 1, 8'h00,    0, 0, 0, 8'h00, 0, 0, 0, 0);
    // fill, overflow, push+pop while full, drain
    add(1, 1, 0, 8'h15,    1, 0, 0, 8'h15, 0, 0, 0, 0);
    add(1, 1, 0, 8'h16,    1, 0, 0, 8'h15, 0, 0, 0, 0);
    add(1, 1, 0, 8'h17,    1, 0, 0, 8'h15, 0, 0, 0, 0);
    add(1, 1, 0, 8'h18,    1, 0, 0, 8'h15, 0, 1, 0, 0);
    add(1, 1, 0, 8'h19,    1, 0, 0, 8'h15, 0, 1, 1, 0);
    add(1, 1, 1, 8'h1A,    1, 0, 0, 8'h16, 0, 1, 1, 0);
    add(1, 0, 1, 8'h00,    1, 0, 0, 8'h17, 0, 0, 1, 0);
    add(1, 0, 1, 8'h00,    1, 0, 0, 8'h18, 0, 0, 1, 0);
    add(1, 0, 1, 8'h00,    1, 0, 0, 8'h1A, 0, 0, 1, 0);
    add(1, 0, 1, 8'h00,    0, 0, 0, 8'h00, 0, 0, 1, 0);
    // push+pop while empty: pop ignored
    add(1, 1, 1, 8'h2B,    1, 0, 0, 8'h2B, 0, 0, 1, 0);
    add(1, 0, 1, 8'h00,    0, 0, 0, 8'h00, 0, 0, 1, 0);
    // F0 F0 protocol error
    add(1, 1, 0, 8'hF0,    0, 0, 0, 8'h00, 0, 0, 1, 0);
    add(1, 1, 0, 8'hF0,    0, 0, 0, 8'h00, 0, 0, 1, 1);
    add(1, 0, 0, 8'h00,    0, 0, 0, 8'h00, 0, 0, 1, 0);
    // reset while in EXT_BRK
    add(1, 1, 0, 8'hE0,    0, 0, 0, 8'h00, 0, 0, 1, 0);
    add(1, 1, 0, 8'hF0,    0, 0, 0, 8'h00, 0, 0, 1, 0);
    add(0, 0, 0, 8'h00,    0, 0, 0, 8'h00, 0, 0, 0, 0);
    add(1, 0, 0, 8'h00,    0, 0, 0, 8'h00, 0, 0, 0, 0);
    add(1, 1, 0, 8'h1C,    1, 0, 0, 8'h1C, 0, 0, 0, 0);
    add(1, 0, 1, 8'h00,    0, 0, 0, 8'h00, 0, 0, 0, 0);
    // prefix after E0 F0 is an error
    add(1, 1, 0, 8'hE0,    0, 0, 0, 8'h00, 0, 0, 0, 0);
    add(1, 1, 0, 8'hF0,    0, 0, 0, 8'h00, 0, 0, 0, 0);
    add(1, 1, 0, 8'hE0,    0, 0, 0, 8'h00, 0, 0, 0, 1);
    add(1, 0, 0, 8'h00,    0, 0, 0, 8'h00, 0, 0, 0, 0);
    // right shift: extended 59 never touches shift_on
    add(1, 1, 0, 8'hE0,    0, 0, 0, 8'h00, 0, 0, 0, 0);
    add(1, 1, 0, 8'h59,    1, 1, 0, 8'h59, 0, 0, 0, 0);
    add(1, 0, 1, 8'h00,    0, 0, 0, 8'h00, 0, 0, 0, 0);
    add(1, 1, 0, 8'h59,    1, 0, 0, 8'h59, 1, 0, 0, 0);
    add(1, 1, 0, 8'hE0,    1, 0, 0, 8'h59, 1, 0, 0, 0);
    add(1, 1, 0, 8'hF0,    1, 0, 0, 8'h59, 1, 0, 0, 0);
    add(1, 1, 0, 8'h59,    1, 0, 0, 8'h59, 1, 0, 0, 0);
    add(1, 1, 0, 8'hF0,    1, 0, 0, 8'h59, 1, 0, 0, 0);
    add(1, 1, 0, 8'h59,    1, 0, 0, 8'h59, 0, 0, 0, 0);
    add(1, 0, 1, 8'h00,    1, 1, 1, 8'h59, 0, 0, 0, 0);
    add(1, 0, 1, 8'h00,    1, 0, 1, 8'h59, 0, 0, 0, 0);
    add(1, 0, 1, 8'h00,    0, 0, 0, 8'h00, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_n, vecs[i].tick, vecs[i].rd, vecs[i].scan);
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Timeout: E0 then silence; abort expected 16 cycles after the tick edge.
    begin
      int waited;
      logic seen;
      drive(1, 1, 0, 8'hE0);
      check("tout_ext_entry", outs(), 15'b0);
      @(negedge clk);
      scan_done_tick = 1'b0; scan_out = 8'h00;
      waited = 1;
      seen = 1'b0;
      for (int c = 1; c <= 40 && !seen; c++) begin
        @(posedge clk);
        #1;
        waited = c;
        seen = err_tick;
      end
      check("tout_err_seen", {14'b0, seen}, 15'd1);
      check("tout_latency", 15'(waited), 15'd16);
      @(posedge clk);
      #1;
      check("tout_err_pulse", outs(), 15'b0);
      drive(1, 1, 0, 8'h1C);
      check("tout_next_make", outs(), {1'b1, 1'b0, 1'b0, 8'h1C, 4'b0000});
      drive(1, 0, 1, 8'h00);
      check("tout_drain", outs(), 15'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
